// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: buffers scan-code bytes and sends device-clocked 11-bit frames on
// open-drain CLK/DATA, backing off on host inhibit. PS2_TX_FIFO_EN selects the multi-entry FIFO.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 286,
  parameter int IDLE_GAP    = 358
`ifdef PS2_TX_FIFO_EN
  ,
  parameter int FIFO_AW     = 3
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_o,
  input  logic       ps2_data_i,
  output logic       ps2_data_o,
  output logic       busy,
  output logic       abort_p,
  output logic [2:0] state_dbg
);

  localparam int GAP_W = $clog2(IDLE_GAP + 1);
  localparam int PH_W  = $clog2(HALF_PERIOD + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GAP   = 3'd1,
    SETUP = 3'd2,
    LOW   = 3'd3,
    ABORT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic [PH_W-1:0]  phase_cnt, phase_next;
  logic [3:0]       bit_idx, bit_next;
  logic [10:0]      frame_q, frame_next;
  logic             load, pop, push;
  logic             clk_s1, clk_s, data_s1, data_s;
  logic             buf_empty;
  logic [7:0]       head_data;
  logic             in_ready_q;

  assign push      = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s   <= 1'b1;
      data_s1 <= 1'b1;
      data_s  <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_i;
      clk_s   <= clk_s1;
      data_s1 <= ps2_data_i;
      data_s  <= data_s1;
    end
  end

`ifdef PS2_TX_FIFO_EN
  localparam int DEPTH = 2 ** FIFO_AW;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_next;

  always_comb count_next = count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // The head entry is only retired once its stop bit is out, so an aborted byte is simply resent.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      in_ready_q <= (count_next != (FIFO_AW + 1)'(DEPTH));
    end
  end

  assign buf_empty = (count == '0);
  assign head_data = mem[rd_ptr];
`else
  logic [7:0] hold_q;
  logic       hold_v;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q     <= 8'h00;
      hold_v     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) hold_q <= in_data;
      if (push) begin
        hold_v     <= 1'b1;
        in_ready_q <= 1'b0;
      end else if (pop) begin
        hold_v     <= 1'b0;
        in_ready_q <= 1'b1;
      end
    end
  end

  assign buf_empty = ~hold_v;
  assign head_data = hold_q;
`endif

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    phase_next = phase_cnt;
    bit_next   = bit_idx;
    load       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        gap_next = '0;
        if (!buf_empty) state_next = GAP;
      end
      GAP: begin
        // A host request-to-send (DATA low) or inhibit keeps the idle counter at zero.
        if (clk_s && data_s) begin
          if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
            state_next = SETUP;
            load       = 1'b1;
            bit_next   = 4'd0;
            phase_next = '0;
          end else begin
            gap_next = gap_cnt + 1'b1;
          end
        end else begin
          gap_next = '0;
        end
      end
      SETUP: begin
        if (phase_cnt == PH_W'(HALF_PERIOD - 1)) begin
          phase_next = '0;
          state_next = clk_s ? LOW : ABORT;
        end else begin
          phase_next = phase_cnt + 1'b1;
        end
      end
      LOW: begin
        if (phase_cnt == PH_W'(HALF_PERIOD - 1)) begin
          phase_next = '0;
          if (bit_idx == 4'd10) begin
            state_next = DONE;
            pop        = 1'b1;
          end else begin
            bit_next   = bit_idx + 1'b1;
            state_next = SETUP;
          end
        end else begin
          phase_next = phase_cnt + 1'b1;
        end
      end
      ABORT: begin
        gap_next   = '0;
        state_next = GAP;
      end
      DONE: begin
        gap_next   = '0;
        state_next = buf_empty ? IDLE : GAP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_next = frame_q;
    if (load) frame_next = {1'b1, ~^head_data, head_data, 1'b0};
  end

  // Line drivers are registered from the next state so the open-drain outputs never glitch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      phase_cnt  <= '0;
      bit_idx    <= 4'd0;
      frame_q    <= 11'h7FF;
      ps2_clk_o  <= 1'b1;
      ps2_data_o <= 1'b1;
      busy       <= 1'b0;
      abort_p    <= 1'b0;
    end else begin
      state      <= state_next;
      gap_cnt    <= gap_next;
      phase_cnt  <= phase_next;
      bit_idx    <= bit_next;
      frame_q    <= frame_next;
      ps2_clk_o  <= (state_next != LOW);
      ps2_data_o <= (state_next == SETUP || state_next == LOW) ? frame_next[bit_next] : 1'b1;
      busy       <= (state_next == SETUP || state_next == LOW ||
                     state_next == ABORT || state_next == DONE);
      abort_p    <= (state_next == ABORT);
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: frame vectors, host inhibit/RTS, mid-frame reset and,
// when PS2_TX_FIFO_EN is defined, FIFO fill/overflow ordering.
module tb_ps2_device_tx;

  localparam int HP  = 286;
  localparam int GAP = 358;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ps2_clk_i, ps2_clk_o, ps2_data_i, ps2_data_o;
  logic       busy, abort_p;
  logic [2:0] state_dbg;
  logic       host_clk = 1'b1;
  logic       host_data = 1'b1;

  // Wired-AND bus: either side can pull a line low.
  assign ps2_clk_i  = ps2_clk_o & host_clk;
  assign ps2_data_i = ps2_data_o & host_data;

  ps2_device_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_data_i (ps2_data_i),
    .ps2_data_o (ps2_data_o),
    .busy       (busy),
    .abort_p    (abort_p),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // bit i = i-th bit on the wire
  } vec_t;
  vec_t vecs[3];

`ifdef PS2_TX_FIFO_EN
  localparam logic EXP_READY_AFTER_PUSH = 1'b1;
`else
  localparam logic EXP_READY_AFTER_PUSH = 1'b0;
`endif

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] d, input logic [10:0] f, output int t);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    t        = cyc;
    exp_q.push_back(f);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_busy(input int budget, output int t);
    t = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy) begin
        t = cyc;
        return;
      end
    end
    check("busy_timeout", 0, 1);
  endtask

  task automatic watch_idle(input string name, input int n);
    int seen;
    seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check(name, seen, 0);
  endtask

  // Walk to the SETUP half-period of bit n (n falling edges done, clock released again).
  task automatic wait_setup_of_bit(input int n, input int budget);
    int falls;
    logic prev;
    falls = 0;
    prev  = ps2_clk_o;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (prev && !ps2_clk_o) falls++;
      prev = ps2_clk_o;
      if (falls == n && ps2_clk_o) return;
    end
    check("setup_wait_timeout", 0, 1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic run_frame(input int budget);
    logic prev, done;
    int n, low;
    logic [10:0] f;
    prev = ps2_clk_o;
    n = 0;
    low = 0;
    f = '1;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (abort_p) begin
        check("unexpected_abort", 1, 0);
        return;
      end
      if (prev && !ps2_clk_o) begin
        if (n < 11) f[n] = ps2_data_o;
        n++;
        low = 1;
      end else if (!ps2_clk_o) begin
        low++;
      end else if (!prev && ps2_clk_o) begin
        check("clk_low_len", low, HP);
        if (n == 11) done = 1'b1;
      end
      prev = ps2_clk_o;
    end
    if (!done) begin
      check("frame_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
    else check("frame_bits", f, exp_q.pop_front());
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int tp, tb, tr, seen;

    vecs[0] = '{data: 8'h1C, frame: 11'h438};
    vecs[1] = '{data: 8'hF0, frame: 11'h7E0};
    vecs[2] = '{data: 8'hFF, frame: 11'h7FE};

    repeat (3) @(negedge clk);
    check("rst_clk_o", ps2_clk_o, 1);
    check("rst_data_o", ps2_data_o, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_abort_p", abort_p, 0);
    check("rst_state", state_dbg, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain frames from the vector table.
    foreach (vecs[i]) begin
      push_byte(vecs[i].data, vecs[i].frame, tp);
      check("ready_after_push", in_ready, EXP_READY_AFTER_PUSH);
      wait_busy(GAP + 50, tb);
      check_range("start_gap", tb - tp, GAP, GAP + 4);
      run_frame(HP * 2 * 11 + 50);
      check("ready_after_frame", in_ready, 1);
      @(negedge clk);
      check("busy_after_frame", busy, 0);
    end

    // Host inhibit during bit 5 setup: abort, release, then full resend.
    push_byte(8'h1C, 11'h438, tp);
    wait_busy(GAP + 50, tb);
    wait_setup_of_bit(5, HP * 2 * 6 + 50);
    host_clk = 1'b0;
    seen = 0;
    for (int c = 0; c < HP + 20 && !seen; c++) begin
      @(negedge clk);
      if (abort_p) seen = 1;
    end
    check("abort_seen", seen, 1);
    check("abort_clk_rel", ps2_clk_o, 1);
    check("abort_data_rel", ps2_data_o, 1);
    @(negedge clk);
    check("abort_one_cycle", abort_p, 0);
    watch_idle("inhibit_hold_idle", 400);
    host_clk = 1'b1;
    tr = cyc;
    wait_busy(GAP + 50, tb);
    check_range("resend_gap", tb - tr, GAP, GAP + 6);
    run_frame(HP * 2 * 11 + 50);
    @(negedge clk);
    check("busy_after_resend", busy, 0);

    // Reset in the middle of bit 4 of 0xAA: lines released at once, byte not resent.
    push_byte(8'hAA, 11'h754, tp);
    wait_busy(GAP + 50, tb);
    wait_setup_of_bit(4, HP * 2 * 5 + 50);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_clk_o", ps2_clk_o, 1);
    check("midrst_data_o", ps2_data_o, 1);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    exp_q.delete();
    watch_idle("no_resend_after_rst", 1000);

    // Host RTS (DATA held low) keeps the frame from starting.
    host_data = 1'b0;
    push_byte(8'h1C, 11'h438, tp);
    watch_idle("rts_hold_idle", 1000);
    check("rts_state_gap", state_dbg, 1);
    host_data = 1'b1;
    tr = cyc;
    wait_busy(GAP + 50, tb);
    check_range("rts_release_gap", tb - tr, GAP, GAP + 6);
    check("rts_start_bit", ps2_data_o, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();

`ifdef PS2_TX_FIFO_EN
    // Nine back-to-back pushes into an eight-entry FIFO: the ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("fifo_ready_before_push", in_ready, (i < 8) ? 1 : 0);
      in_data  = 8'(i + 1);
      in_valid = 1'b1;
      if (i < 8) exp_q.push_back(frame_of(8'(i + 1)));
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("fifo_full_ready", in_ready, 0);
    for (int k = 0; k < 8; k++) begin
      wait_busy(GAP + 50, tb);
      run_frame(HP * 2 * 11 + 50);
      if (k == 0) check("fifo_ready_after_pop", in_ready, 1);
    end
    watch_idle("fifo_no_ninth", 500);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
